// File: rtl/fractal_sync_cam_sched.sv
// -----------------------------------------------------------------------------
// fractal_sync_cam_sched
//
// Request scheduler and rendezvous tracker in front of fractal_sync_mp_cam.
// Each of N_REQ requester slots runs a small IDLE/PEND/WAIT/DONE FSM. PEND
// slots are granted round-robin onto the N_PORTS CAM ports. A grant that hits
// in the CAM completes the rendezvous for both the granted slot and the WAIT
// slot that holds the same signature. A grant that misses stores its
// signature if a CAM line is free. Otherwise it retries on a later cycle.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_valid_i       per-slot request valid
//   req_sig_i         per-slot signature, slot s at [s*SIG_WIDTH +: SIG_WIDTH]
//   req_ready_o       per-slot: slot is IDLE and can accept a request
//   rsp_valid_o       per-slot one-cycle pulse when the rendezvous completes
//   cam_sig_o         per-port lookup/store signature (0 when the port is idle)
//   cam_write_o       per-port store strobe
//   cam_present_i     per-port CAM hit, combinational in the grant cycle
//   occupancy_o       number of CAM lines holding a waiting signature
//   stat_hits_o       saturating hit counter (0 unless stats are enabled)
//   stat_stores_o     saturating store counter (0 unless stats are enabled)
//
// Optional feature: define FRACTAL_SYNC_CAM_SCHED_STATS_EN to enable the
// hit/store statistics counters. Without it, both stat ports are tied to 0.
// -----------------------------------------------------------------------------
module fractal_sync_cam_sched #(
  parameter int SIG_WIDTH = 8,
  parameter int N_REQ     = 4,
  parameter int N_PORTS   = 2,
  parameter int N_LINES   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_valid_i,
  input  logic [N_REQ*SIG_WIDTH-1:0]     req_sig_i,
  output logic [N_REQ-1:0]               req_ready_o,
  output logic [N_REQ-1:0]               rsp_valid_o,
  output logic [N_PORTS*SIG_WIDTH-1:0]   cam_sig_o,
  output logic [N_PORTS-1:0]             cam_write_o,
  input  logic [N_PORTS-1:0]             cam_present_i,
  output logic [$clog2(N_LINES+1)-1:0]   occupancy_o,
  output logic [31:0]                    stat_hits_o,
  output logic [31:0]                    stat_stores_o
);

  localparam int OCC_W  = $clog2(N_LINES + 1);
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GCNT_W = $clog2(N_PORTS + 1);
  localparam logic [PTR_W:0] N_REQ_W = (PTR_W + 1)'(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_DONE} slot_state_e;

  slot_state_e          state_q [N_REQ];
  slot_state_e          state_d [N_REQ];
  logic [SIG_WIDTH-1:0] sig_q   [N_REQ];
  logic [SIG_WIDTH-1:0] sig_d   [N_REQ];
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;

  // Per-port grant information produced by the arbiter.
  logic                 grant_vld  [N_PORTS];
  logic [PTR_W-1:0]     grant_slot [N_PORTS];
  logic [SIG_WIDTH-1:0] grant_sig  [N_PORTS];
  logic [N_PORTS-1:0]   port_hit;
  logic [N_PORTS-1:0]   port_store;
  logic [GCNT_W-1:0]    n_hit;
  logic [GCNT_W-1:0]    n_store;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < N_REQ; s++) state_q[s] <= S_IDLE;
      rr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int s = 0; s < N_REQ; s++) state_q[s] <= state_d[s];
      rr_ptr_q <= rr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: the signature registers are deliberately left without reset. A
  // slot's signature is only observed once the slot has left IDLE, and
  // leaving IDLE always reloads it.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < N_REQ; s++) sig_q[s] <= sig_d[s];
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter with same-signature de-duplication
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [GCNT_W-1:0] n_grant;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  idx;
    logic              dup;
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    n_grant  = '0;
    sum      = '0;
    idx      = '0;
    dup      = 1'b0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < N_PORTS; k++) begin
      grant_vld[k]  = 1'b0;
      grant_slot[k] = '0;
      grant_sig[k]  = '0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      // Visit slots in rotated order, starting at the round-robin pointer.
      sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(i);
      if (sum >= N_REQ_W) sum = sum - N_REQ_W;
      idx = sum[PTR_W-1:0];
      // A second slot with an already-granted signature must wait. It will
      // then find the first slot's stored signature and hit.
      dup = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
        if (grant_vld[k] && grant_sig[k] == sig_q[idx]) dup = 1'b1;
      end
      if (state_q[idx] == S_PEND && !dup && n_grant < GCNT_W'(N_PORTS)) begin
        for (int k = 0; k < N_PORTS; k++) begin
          if (GCNT_W'(k) == n_grant) begin
            grant_vld[k]  = 1'b1;
            grant_slot[k] = idx;
            grant_sig[k]  = sig_q[idx];
          end
        end
        n_grant  = n_grant + 1'b1;
        rr_ptr_d = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port resolution: hits, and stores limited by free CAM lines
  // ---------------------------------------------------------------------------
  always_comb begin
    n_hit      = '0;
    n_store    = '0;
    port_hit   = '0;
    port_store = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant_vld[k]) begin
        if (cam_present_i[k]) begin
          port_hit[k] = 1'b1;
          n_hit       = n_hit + 1'b1;
        end else if (int'(occ_q) + int'(n_store) < N_LINES) begin
          // Lines freed by same-cycle hits are not reused until next cycle.
          port_store[k] = 1'b1;
          n_store       = n_store + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for every slot FSM and the occupancy count
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int s = 0; s < N_REQ; s++) begin
      state_d[s] = state_q[s];
      sig_d[s]   = sig_q[s];
      case (state_q[s])
        S_IDLE: begin
          if (req_valid_i[s]) begin
            sig_d[s]   = req_sig_i[s*SIG_WIDTH +: SIG_WIDTH];
            state_d[s] = S_PEND;
          end
        end
        S_PEND: begin
          for (int k = 0; k < N_PORTS; k++) begin
            if (grant_vld[k] && grant_slot[k] == PTR_W'(s)) begin
              if (port_hit[k])        state_d[s] = S_DONE;
              else if (port_store[k]) state_d[s] = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Stored signatures are unique, so at most one WAIT slot matches.
          for (int k = 0; k < N_PORTS; k++) begin
            if (port_hit[k] && grant_sig[k] == sig_q[s]) state_d[s] = S_DONE;
          end
        end
        S_DONE:  state_d[s] = S_IDLE;
        default: state_d[s] = S_IDLE;
      endcase
    end
    occ_d = occ_q + OCC_W'(n_store) - OCC_W'(n_hit);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int s = 0; s < N_REQ; s++) begin
      req_ready_o[s] = (state_q[s] == S_IDLE);
      rsp_valid_o[s] = (state_q[s] == S_DONE);
    end
    for (int k = 0; k < N_PORTS; k++) begin
      cam_sig_o[k*SIG_WIDTH +: SIG_WIDTH] = grant_sig[k];
      cam_write_o[k]                      = port_store[k];
    end
    occupancy_o = occ_q;
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef FRACTAL_SYNC_CAM_SCHED_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_stores_q, stat_stores_d;

  always_comb begin
    logic [32:0] hits_sum;
    logic [32:0] stores_sum;
    hits_sum      = {1'b0, stat_hits_q} + 33'(n_hit);
    stores_sum    = {1'b0, stat_stores_q} + 33'(n_store);
    stat_hits_d   = hits_sum[32] ? '1 : hits_sum[31:0];
    stat_stores_d = stores_sum[32] ? '1 : stores_sum[31:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_hits_q   <= '0;
      stat_stores_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_stores_q <= stat_stores_d;
    end
  end

  assign stat_hits_o   = stat_hits_q;
  assign stat_stores_o = stat_stores_q;
`else
  assign stat_hits_o   = '0;
  assign stat_stores_o = '0;
`endif

endmodule
